alu_stream_pipe: RTL and testbench

- Parametrised successor to the single-width ALU/FIFO datapath.
- Accepts packed commands {op, b, a} on a valid/ready input stream and buffers them in an input FIFO.
- Executes each command in one registered ALU stage, then buffers {err, result} in an output FIFO on a valid/ready output stream.
- Full backpressure on both sides, in-order results, one op per cycle sustained.

---
 rtl/alu_stream_pipe_if.sv | 44 ++++
 rtl/alu_stream_pipe.sv | 197 +++++++++++++++++++
 tb/tb_alu_stream_pipe.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_stream_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_stream_pipe_if
//  Description : Stream bundle for alu_stream_pipe. It carries the command
//                input stream, the result output stream and the two FIFO
//                occupancy outputs.
//                  in_data   {op[2:0], b, a}, a in LSBs
//                  in_valid  command present
//                  in_ready  block can accept a command
//                  out_data  {err, result}, zero while out_valid=0
//                  out_valid result present
//                  out_ready consumer accepts the result
//                  in_level  input FIFO occupancy
//                  out_level output FIFO occupancy
//                Modports: master = producer/consumer side, slave = block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_stream_pipe_if #(
  parameter int DATA_W    = 4,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
);
  localparam int RES_W = 2 * DATA_W;

  logic [2*DATA_W+2:0]         in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [RES_W:0]              out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [$clog2(IN_DEPTH):0]   in_level;
  logic [$clog2(OUT_DEPTH):0]  out_level;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, in_level, out_level
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, in_level, out_level
  );
endinterface
`default_nettype wire

// File: rtl/alu_stream_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_stream_pipe
//  Description : Streaming ALU. Commands {op, b, a} are buffered in an input
//                FIFO, executed in one registered ALU stage, and the
//                {err, result} words are buffered in an output FIFO. Full
//                backpressure on both streams, results in command order,
//                one operation per cycle sustained.
//  Ports       : clk     - single clock, rising edge
//                reset   - asynchronous, active-low reset
//                bus     - alu_stream_pipe_if.slave (in/out streams, levels)
//  Options     : ALU_LOGIC_OPS_EN - when defined, ops 4-7 perform and/or/
//                xor/shift-left; otherwise they return result=0, err=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_stream_pipe #(
  parameter int DATA_W    = 4,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  alu_stream_pipe_if.slave   bus
);

  localparam int RES_W  = 2 * DATA_W;
  localparam int CMD_W  = 2 * DATA_W + 3;
  localparam int OUT_W  = RES_W + 1;
  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);

  localparam logic [IN_AW:0]  IN_FULL_LVL  = (IN_AW+1)'(IN_DEPTH);
  localparam logic [OUT_AW:0] OUT_FULL_LVL = (OUT_AW+1)'(OUT_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CMD_W-1:0]  in_mem_q  [IN_DEPTH];
  logic [IN_AW-1:0]  in_wr_ptr_q, in_wr_ptr_d;
  logic [IN_AW-1:0]  in_rd_ptr_q, in_rd_ptr_d;
  logic [IN_AW:0]    in_level_q,  in_level_d;

  logic              stage_valid_q, stage_valid_d;
  logic [OUT_W-1:0]  stage_data_q,  stage_data_d;

  logic [OUT_W-1:0]  out_mem_q [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wr_ptr_q, out_wr_ptr_d;
  logic [OUT_AW-1:0] out_rd_ptr_q, out_rd_ptr_d;
  logic [OUT_AW:0]   out_level_q,  out_level_d;

  // --------------------------------------------------------------------------
  // Handshake decisions (all from registered levels, no bypass paths)
  // --------------------------------------------------------------------------
  logic w_in_ready;
  logic w_in_push;
  logic w_stage_drain;
  logic w_stage_load;
  logic w_out_valid;
  logic w_out_pop;

  assign w_in_ready    = (in_level_q != IN_FULL_LVL);
  assign w_in_push     = bus.in_valid && w_in_ready;
  assign w_stage_drain = stage_valid_q && (out_level_q != OUT_FULL_LVL);
  // The stage refills on the same edge it empties, giving 1 op/cycle.
  assign w_stage_load  = (in_level_q != '0) && (!stage_valid_q || w_stage_drain);
  assign w_out_valid   = (out_level_q != '0);
  assign w_out_pop     = w_out_valid && bus.out_ready;

  // --------------------------------------------------------------------------
  // ALU on the input FIFO head
  // --------------------------------------------------------------------------
  logic [CMD_W-1:0]  w_head;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [2:0]        w_op;
  logic [RES_W-1:0]  w_a_ext;
  logic [RES_W-1:0]  w_b_ext;
  logic [RES_W-1:0]  w_res;
  logic              w_err;

  assign w_head  = in_mem_q[in_rd_ptr_q];
  assign w_a     = w_head[DATA_W-1:0];
  assign w_b     = w_head[2*DATA_W-1:DATA_W];
  assign w_op    = w_head[CMD_W-1 -: 3];
  assign w_a_ext = RES_W'(w_a);
  assign w_b_ext = RES_W'(w_b);

`ifdef ALU_LOGIC_OPS_EN
  logic [DATA_W-1:0] w_shamt;
  assign w_shamt = DATA_W'(32'(w_b) % DATA_W);
`endif

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (w_op)
      3'd0: w_res = w_a_ext + w_b_ext;
      3'd1: w_res = w_a_ext - w_b_ext;
      3'd2: w_res = w_a_ext * w_b_ext;
      3'd3: begin
        if (w_b == '0) begin
          w_res = '1;
          w_err = 1'b1;
        end else begin
          w_res = w_a_ext / w_b_ext;
        end
      end
`ifdef ALU_LOGIC_OPS_EN
      3'd4:    w_res = w_a_ext & w_b_ext;
      3'd5:    w_res = w_a_ext | w_b_ext;
      3'd6:    w_res = w_a_ext ^ w_b_ext;
      default: w_res = w_a_ext << w_shamt;
`else
      default: begin
        w_res = '0;
        w_err = 1'b1;
      end
`endif
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    in_wr_ptr_d   = in_wr_ptr_q;
    in_rd_ptr_d   = in_rd_ptr_q;
    in_level_d    = in_level_q;
    stage_valid_d = stage_valid_q;
    stage_data_d  = stage_data_q;
    out_wr_ptr_d  = out_wr_ptr_q;
    out_rd_ptr_d  = out_rd_ptr_q;
    out_level_d   = out_level_q;

    // Pointers are exactly log2(depth) wide, so they wrap naturally.
    if (w_in_push)    in_wr_ptr_d = in_wr_ptr_q + IN_AW'(1);
    if (w_stage_load) in_rd_ptr_d = in_rd_ptr_q + IN_AW'(1);
    case ({w_in_push, w_stage_load})
      2'b10:   in_level_d = in_level_q + (IN_AW+1)'(1);
      2'b01:   in_level_d = in_level_q - (IN_AW+1)'(1);
      default: in_level_d = in_level_q;
    endcase

    stage_valid_d = w_stage_load || (stage_valid_q && !w_stage_drain);
    if (w_stage_load) stage_data_d = {w_err, w_res};

    if (w_stage_drain) out_wr_ptr_d = out_wr_ptr_q + OUT_AW'(1);
    if (w_out_pop)     out_rd_ptr_d = out_rd_ptr_q + OUT_AW'(1);
    case ({w_stage_drain, w_out_pop})
      2'b10:   out_level_d = out_level_q + (OUT_AW+1)'(1);
      2'b01:   out_level_d = out_level_q - (OUT_AW+1)'(1);
      default: out_level_d = out_level_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr_ptr_q   <= '0;
      in_rd_ptr_q   <= '0;
      in_level_q    <= '0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      out_wr_ptr_q  <= '0;
      out_rd_ptr_q  <= '0;
      out_level_q   <= '0;
    end else begin
      in_wr_ptr_q   <= in_wr_ptr_d;
      in_rd_ptr_q   <= in_rd_ptr_d;
      in_level_q    <= in_level_d;
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      out_wr_ptr_q  <= out_wr_ptr_d;
      out_rd_ptr_q  <= out_rd_ptr_d;
      out_level_q   <= out_level_d;
    end
  end

  // FIFO storage keeps its contents across reset; only pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_in_push)     in_mem_q[in_wr_ptr_q]   <= bus.in_data;
    if (w_stage_drain) out_mem_q[out_wr_ptr_q] <= stage_data_q;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? out_mem_q[out_rd_ptr_q] : '0;
  assign bus.in_level  = in_level_q;
  assign bus.out_level = out_level_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_stream_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_stream_pipe
//  Description : Directed self-checking bench for alu_stream_pipe
//                (DATA_W=4, IN_DEPTH=8, OUT_DEPTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_stream_pipe;

  localparam int DATA_W    = 4;
  localparam int IN_DEPTH  = 8;
  localparam int OUT_DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [8:0] got_q[$];
  int         got_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_stream_pipe_if #(.DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) bus ();

  alu_stream_pipe #(.DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Record every result that is popped (inputs are stable between negedge
  // and the following posedge).
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
      got_cyc.push_back(cyc);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the push edge.
  task automatic send_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int t;
    t = 0;
    bus.in_data  = {op, b, a};
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  task automatic test_reset;
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = {3'd0, 4'd2, 4'd1};
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 9'h0)  begin n_fail++; $display("FAIL rst_out_data: got %h want 000", bus.out_data); end
    n_cmp++; if (bus.in_level !== 4'd0)  begin n_fail++; $display("FAIL rst_in_level: got %0d want 0", bus.in_level); end
    n_cmp++; if (bus.out_level !== 4'd0) begin n_fail++; $display("FAIL rst_out_level: got %0d want 0", bus.out_level); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;          // edge E: command accepted
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.in_level !== 4'd1) begin n_fail++; $display("FAIL lat_E_in_level: got %0d want 1", bus.in_level); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_E_out_valid: got %0b want 0", bus.out_valid); end
    @(negedge clk);              // after E+1
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_E1_out_valid: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_level !== 4'd0) begin n_fail++; $display("FAIL lat_E1_in_level: got %0d want 0", bus.in_level); end
    @(negedge clk);              // after E+2
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_E2_out_valid: got %0b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 9'h003) begin n_fail++; $display("FAIL lat_E2_out_data: got %h want 003", bus.out_data); end
    repeat (3) @(posedge clk);
    #1;
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_basic_ops;
    logic [8:0] exp [5];
    exp = '{9'h00E, 9'h004, 9'h02D, 9'h001, 9'h0FE};
    send_cmd(3'd0, 4'd9, 4'd5);
    send_cmd(3'd1, 4'd9, 4'd5);
    send_cmd(3'd2, 4'd9, 4'd5);
    send_cmd(3'd3, 4'd9, 4'd5);
    send_cmd(3'd1, 4'd3, 4'd5);
    wait_results(5);
    n_cmp++; if (got_q.size() !== 5) begin n_fail++; $display("FAIL basic_count: got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) begin
        n_cmp++;
        if (got_q[i] !== exp[i]) begin n_fail++; $display("FAIL basic_op%0d: got %h want %h", i, got_q[i], exp[i]); end
      end
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_div_zero;
    send_cmd(3'd3, 4'd7, 4'd0);
    send_cmd(3'd3, 4'd8, 4'd2);
    wait_results(2);
    n_cmp++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL div0_count: got %0d want 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_cmp++; if (got_q[0] !== 9'h1FF) begin n_fail++; $display("FAIL div0_result: got %h want 1FF", got_q[0]); end
      n_cmp++; if (got_q[1] !== 9'h004) begin n_fail++; $display("FAIL div_after_div0: got %h want 004", got_q[1]); end
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_backpressure;
    int idx;
    int gaps;
    logic [8:0] expv;
    idx = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (idx < 20) begin
        bus.in_data  = {3'd0, (idx >= 16) ? 4'd1 : 4'd0, 4'(idx)};
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++; if (idx !== 17) begin n_fail++; $display("FAIL bp_accepted: got %0d want 17", idx); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b want 0", bus.in_ready); end
    n_cmp++; if (bus.in_level !== 4'd8) begin n_fail++; $display("FAIL bp_in_level: got %0d want 8", bus.in_level); end
    n_cmp++; if (bus.out_level !== 4'd8) begin n_fail++; $display("FAIL bp_out_level: got %0d want 8", bus.out_level); end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_results(17);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() !== 17) begin n_fail++; $display("FAIL bp_result_count: got %0d want 17", got_q.size()); end
    gaps = 0;
    for (int i = 0; i < 17; i++) begin
      if (i < got_q.size()) begin
        expv = (i < 16) ? 9'(i) : 9'h001;
        n_cmp++;
        if (got_q[i] !== expv) begin n_fail++; $display("FAIL bp_order%0d: got %h want %h", i, got_q[i], expv); end
        if (i > 0 && got_cyc[i] - got_cyc[i-1] != 1) gaps++;
      end
    end
    n_cmp++; if (gaps !== 0) begin n_fail++; $display("FAIL bp_throughput: got %0d gaps want 0", gaps); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after: got %0b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_level !== 4'd0) begin n_fail++; $display("FAIL bp_out_level_after: got %0d want 0", bus.out_level); end
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_cmd(3'd0, 4'(i), 4'd1);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_level !== 4'd5) begin n_fail++; $display("FAIL rmid_pre_level: got %0d want 5", bus.out_level); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.in_level !== 4'd0)  begin n_fail++; $display("FAIL rmid_in_level: got %0d want 0", bus.in_level); end
    n_cmp++; if (bus.out_level !== 4'd0) begin n_fail++; $display("FAIL rmid_out_level: got %0d want 0", bus.out_level); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 9'h0)  begin n_fail++; $display("FAIL rmid_out_data: got %h want 000", bus.out_data); end
    @(posedge clk); #1;
    reset = 1'b1;
    got_q.delete();
    got_cyc.delete();
    bus.out_ready = 1'b1;
    send_cmd(3'd0, 4'd2, 4'd3);
    send_cmd(3'd2, 4'd3, 4'd3);
    wait_results(2);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL rmid_count: got %0d want 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_cmp++; if (got_q[0] !== 9'h005) begin n_fail++; $display("FAIL rmid_res0: got %h want 005", got_q[0]); end
      n_cmp++; if (got_q[1] !== 9'h009) begin n_fail++; $display("FAIL rmid_res1: got %h want 009", got_q[1]); end
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_logic_ops;
    logic [8:0] exp_xor;
    logic [8:0] exp_shl;
`ifdef ALU_LOGIC_OPS_EN
    exp_xor = 9'h006;
    exp_shl = 9'h006;
`else
    exp_xor = 9'h100;
    exp_shl = 9'h100;
`endif
    send_cmd(3'd6, 4'hC, 4'hA);
    send_cmd(3'd7, 4'd3, 4'd5);
    send_cmd(3'd0, 4'd1, 4'd1);
    wait_results(3);
    n_cmp++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL logic_count: got %0d want 3", got_q.size()); end
    if (got_q.size() >= 3) begin
      n_cmp++; if (got_q[0] !== exp_xor) begin n_fail++; $display("FAIL logic_xor: got %h want %h", got_q[0], exp_xor); end
      n_cmp++; if (got_q[1] !== exp_shl) begin n_fail++; $display("FAIL logic_shl: got %h want %h", got_q[1], exp_shl); end
      n_cmp++; if (got_q[2] !== 9'h002) begin n_fail++; $display("FAIL logic_next_add: got %h want 002", got_q[2]); end
    end
    got_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b0;
    test_reset();
    test_basic_ops();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_logic_ops();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
